if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h1c000000, giving the first fetch address after reset.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port resetn, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The module SHALL have port inst_sram_req, output, 1 bit, the fetch request valid.
REQ-005 The module SHALL have port inst_sram_addr, output, 32 bits, the fetch address.
REQ-006 The module SHALL have port inst_sram_addr_ok, input, 1 bit; the request is accepted in any cycle where req and addr_ok are both 1.
REQ-007 The module SHALL have port inst_sram_data_ok, input, 1 bit, marking read data returned.
REQ-008 The module SHALL have port inst_sram_rdata, input, 32 bits, read data valid when data_ok is 1.
REQ-009 The module SHALL have port br_taken, input, 1 bit, a one-cycle redirect pulse from EX.
REQ-010 The module SHALL have port br_target, input, 32 bits, the redirect address, valid with br_taken.
REQ-011 The module SHALL have port ds_allowin, input, 1 bit; ID can accept an instruction this cycle.
REQ-012 The module SHALL have port fs_to_ds_valid, output, 1 bit; fs_pc, fs_inst and fs_adef are valid for ID.
REQ-013 The module SHALL have port fs_pc, output, 32 bits, the PC of the presented instruction.
REQ-014 The module SHALL have port fs_inst, output, 32 bits, the instruction word consumed by the ID decoders.
REQ-015 The module SHALL have port fs_adef, output, 1 bit; fs_pc is misaligned and fs_inst is 32'h0.

Function
REQ-016 States SHALL be: REQ (issue fetch), WAIT (one request outstanding), HOLD (instruction buffered for ID); at most one request SHALL be outstanding.
REQ-017 Registers SHALL be: pc (next fetch address), req_pc (address of the outstanding fetch), cancel flag, inst buffer, adef flag.
REQ-018 In REQ with pc[1:0]==0, inst_sram_req SHALL be 1 and inst_sram_addr SHALL equal pc; in every other state or condition, inst_sram_req SHALL be 0.
REQ-019 In REQ on accept: req_pc<=pc, pc<=pc+4 (wraps modulo 2^32), and the next state SHALL be WAIT.
REQ-020 In REQ with pc[1:0]!=0: no request SHALL be issued; instead fs_pc<=pc, fs_adef<=1, fs_inst<=0, pc<=pc+4, and the next state SHALL be HOLD.
REQ-021 In WAIT on data_ok with cancel==0: fs_inst<=rdata, fs_pc<=req_pc, fs_adef<=0, and the next state SHALL be HOLD.
REQ-022 In WAIT on data_ok with cancel==1: data SHALL be discarded, cancel<=0, and the next state SHALL be REQ.
REQ-023 fs_to_ds_valid SHALL equal (state==HOLD) & ~br_taken, which is combinational.
REQ-024 In HOLD with ds_allowin==1 and br_taken==0, the instruction SHALL be consumed and the next state SHALL be REQ; otherwise HOLD and its outputs SHALL stay stable.
REQ-025 Minimum latency: accept in cycle N, data_ok in cycle N+1, fs_to_ds_valid in cycle N+2.
REQ-026 Redirect: br_taken SHALL set pc<=br_target in every state, with priority over the pc+4 update.
REQ-027 br_taken in REQ without accept: the request address SHALL change to br_target in the next cycle (an unaccepted request may change address).
REQ-028 br_taken in REQ with accept in the same cycle: the next state SHALL be WAIT with cancel<=1.
REQ-029 br_taken in WAIT without data_ok: cancel<=1.
REQ-030 br_taken in WAIT with data_ok: data SHALL be discarded and the next state SHALL be REQ.
REQ-031 br_taken in HOLD: the buffer SHALL be dropped, the next state SHALL be REQ, and nothing SHALL be delivered even if ds_allowin==1.
REQ-032 data_ok outside WAIT SHALL be ignored.

Reset
REQ-033 While resetn==0, the block SHALL be asynchronously forced to: state=REQ, pc=RESET_PC, req_pc=0, cancel=0, fs_pc=0, fs_inst=0, fs_adef=0; therefore fs_to_ds_valid=0 and inst_sram_req=0.
REQ-034 inst_sram_req SHALL first assert in the first cycle after resetn deasserts, with addr=RESET_PC.
REQ-035 Reset asserted mid-request SHALL drop any outstanding fetch; a data_ok arriving after reset SHALL be ignored, since the state is REQ.

Verification
REQ-036 Reset release, addr_ok and data_ok each 1 cycle later -> addr 1c000000 then 1c000004; fs_pc=1c000000 with fs_inst=rdata.
REQ-037 ds_allowin=0 for 3 cycles while in HOLD -> fs_to_ds_valid, fs_pc and fs_inst stay stable, and no new request is issued.
REQ-038 br_taken target=1c000100 in WAIT, then data_ok -> data discarded; the next request uses addr 1c000100 and is delivered with fs_pc=1c000100.
REQ-039 br_taken coinciding with addr_ok -> cancel set, the returned word is dropped, and the following request goes to br_target.
REQ-040 br_taken target=1c000102 -> no sram request; fs_to_ds_valid=1, fs_adef=1, fs_pc=1c000102, fs_inst=0.
REQ-041 pc=ffff_fffc fetch -> next request addr 0000_0000 (wrap-around); resetn pulsed low in WAIT -> outputs are immediately at reset values.

Source files
------------

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Issues one fetch at a time to the
//               instruction SRAM via a req/addr_ok/data_ok handshake, buffers
//               the returned word for ID and handles EX redirects, which can
//               cancel a fetch that is already in flight.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk               : clock, all state updates on the rising edge
//   resetn            : asynchronous active-low reset
//   inst_sram_req     : fetch request valid
//   inst_sram_addr    : fetch address
//   inst_sram_addr_ok : request accepted when req and addr_ok are both high
//   inst_sram_data_ok : read data returned
//   inst_sram_rdata   : read data, valid with data_ok
//   br_taken          : one-cycle redirect pulse from EX
//   br_target         : redirect address, valid with br_taken
//   ds_allowin        : ID can accept an instruction this cycle
//   fs_to_ds_valid    : fs_pc / fs_inst / fs_adef are valid for ID
//   fs_pc             : PC of the presented instruction
//   fs_inst           : presented instruction word
//   fs_adef           : fs_pc is misaligned and fs_inst is zero
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        ds_allowin,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        fs_adef
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        cancel;
    logic        aligned;
    logic        accept;

    assign aligned = (pc[1:0] == 2'b00);

    // The request is qualified with resetn so that nothing is presented to
    // the SRAM while reset is held, even though state/pc already hold their
    // post-reset values.
    assign inst_sram_req  = resetn & (state == S_REQ) & aligned;
    assign inst_sram_addr = pc;
    assign accept         = inst_sram_req & inst_sram_addr_ok;

    // A redirect in the same cycle invalidates whatever is being presented.
    assign fs_to_ds_valid = (state == S_HOLD) & ~br_taken;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_REQ;
            pc      <= RESET_PC;
            req_pc  <= 32'h0;
            cancel  <= 1'b0;
            fs_pc   <= 32'h0;
            fs_inst <= 32'h0;
            fs_adef <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (!aligned) begin
                        // Misaligned PC: deliver an address-error bubble
                        // instead of fetching, unless it is on a path that
                        // is being redirected away right now.
                        if (!br_taken) begin
                            fs_pc   <= pc;
                            fs_adef <= 1'b1;
                            fs_inst <= 32'h0;
                            state   <= S_HOLD;
                        end
                    end else if (accept) begin
                        req_pc <= pc;
                        // Fetch accepted together with a redirect is on the
                        // wrong path; mark it so its data is dropped.
                        cancel <= br_taken;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_sram_data_ok) begin
                        if (cancel || br_taken) begin
                            cancel <= 1'b0;
                            state  <= S_REQ;
                        end else begin
                            fs_inst <= inst_sram_rdata;
                            fs_pc   <= req_pc;
                            fs_adef <= 1'b0;
                            state   <= S_HOLD;
                        end
                    end else if (br_taken) begin
                        cancel <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (br_taken || ds_allowin) begin
                        state <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase

            // Redirect wins over sequential advance in every state.
            if (br_taken) begin
                pc <= br_target;
            end else if (state == S_REQ && (accept || !aligned)) begin
                pc <= pc + 32'd4;
            end
        end
    end

endmodule
`default_nettype wire
